// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared Connect Four board constants, codes and types
//
// Holds the board geometry, cell and result codes, the line direction
// enum, the scanner state enum and the packed grid type shared by
// grid_logic, win_scanner and vga_renderer.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    // Cell codes (2'b11 is an invalid cell and never anchors a line)
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    // Result codes reported on winner
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Line directions as (dr,dc): H (0,+1), V (+1,0), DR (+1,+1), DL (+1,-1)
    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_DR = 2'd2,
        DIR_DL = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    // grid[row][col], row 0 at the top, col 0 at the left
    typedef logic [0:ROWS-1][0:COLS-1][1:0] grid_t;

endpackage

// File: rtl/four_in_line.sv
// rtl/four_in_line.sv - combinational test of one (row, col, direction) line
//
// Ports:
//   snap    grid snapshot being scanned
//   r, c    anchor row / column
//   d       direction (dir_e encoding)
//   match   1 when the anchor holds P1/P2, the line is in bounds and all
//           four cells equal the anchor
//   player  anchor cell code when match=1, EMPTY otherwise
module four_in_line
    import connect4_pkg::*;
(
    input  grid_t      snap,
    input  logic [2:0] r,
    input  logic [2:0] c,
    input  logic [1:0] d,
    output logic       match,
    output logic [1:0] player
);

    logic       in_bounds;
    logic [1:0] anchor;
    logic [2:0] rk;
    logic [2:0] ck;
    logic [2:0] kk;

    always_comb begin
        anchor = snap[r][c];

        case (dir_e'(d))
            DIR_H:   in_bounds = (c <= 3'(COLS - 4));
            DIR_V:   in_bounds = (r <= 3'(ROWS - 4));
            DIR_DR:  in_bounds = (r <= 3'(ROWS - 4)) && (c <= 3'(COLS - 4));
            default: in_bounds = (r <= 3'(ROWS - 4)) && (c >= 3'd3);
        endcase

        match = in_bounds && ((anchor == P1) || (anchor == P2));

        // Out-of-bounds lines may wrap the 3-bit coordinates; in_bounds
        // already forces match low, so those reads are don't-care.
        kk = 3'd0;
        rk = r;
        ck = c;
        for (int k = 1; k <= 3; k++) begin
            kk = 3'(k);
            rk = r;
            ck = c;
            case (dir_e'(d))
                DIR_H:   ck = c + kk;
                DIR_V:   rk = r + kk;
                DIR_DR:  begin rk = r + kk; ck = c + kk; end
                default: begin rk = r + kk; ck = c - kk; end
            endcase
            if (snap[rk][ck] != anchor) begin
                match = 1'b0;
            end
        end

        player = match ? anchor : EMPTY;
    end

endmodule

// File: rtl/win_scanner.sv
// rtl/win_scanner.sv - sequential four-in-a-row detector over a grid snapshot
//
// Ports:
//   clk_25     system clock
//   rst_n      synchronous active-low reset
//   start      one-cycle scan request, accepted in IDLE while game_over=0
//   grid       live board from grid_logic, copied on an accepted start
//   busy       high in SCAN and DONE
//   done       one-cycle pulse, result valid in that cycle
//   winner     none / P1 / P2 / draw, held between scans
//   win_row    anchor row of the winning line (0 unless P1/P2 won)
//   win_col    anchor column of the winning line (0 unless P1/P2 won)
//   win_dir    direction of the winning line (0 unless P1/P2 won)
//   game_over  sticky, set by any result other than none; cleared by reset
module win_scanner
    import connect4_pkg::*;
(
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic       start,
    input  grid_t      grid,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic [2:0] win_row,
    output logic [2:0] win_col,
    output logic [1:0] win_dir,
    output logic       game_over
);

    scan_state_e state;
    grid_t       snap;
    logic [2:0]  r_cnt;
    logic [2:0]  c_cnt;
    logic [1:0]  d_cnt;

    logic        line_match;
    logic [1:0]  line_player;
    logic        board_full;
    logic        last_idx;

    four_in_line u_line (
        .snap   (snap),
        .r      (r_cnt),
        .c      (c_cnt),
        .d      (d_cnt),
        .match  (line_match),
        .player (line_player)
    );

    // Invalid cells (11) count as occupied for the draw decision
    always_comb begin
        board_full = 1'b1;
        for (int rr = 0; rr < ROWS; rr++) begin
            for (int cc = 0; cc < COLS; cc++) begin
                if (snap[rr][cc] == EMPTY) begin
                    board_full = 1'b0;
                end
            end
        end
    end

    assign last_idx = (r_cnt == 3'(ROWS - 1)) && (c_cnt == 3'(COLS - 1)) && (d_cnt == 2'd3);

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            snap      <= '0;
            r_cnt     <= 3'd0;
            c_cnt     <= 3'd0;
            d_cnt     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            winner    <= RES_NONE;
            win_row   <= 3'd0;
            win_col   <= 3'd0;
            win_dir   <= 2'd0;
            game_over <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !game_over) begin
                        snap  <= grid;
                        r_cnt <= 3'd0;
                        c_cnt <= 3'd0;
                        d_cnt <= 2'd0;
                        busy  <= 1'b1;
                        state <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (line_match) begin
                        winner    <= (line_player == P1) ? RES_P1 : RES_P2;
                        win_row   <= r_cnt;
                        win_col   <= c_cnt;
                        win_dir   <= d_cnt;
                        game_over <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else if (last_idx) begin
                        winner    <= board_full ? RES_DRAW : RES_NONE;
                        win_row   <= 3'd0;
                        win_col   <= 3'd0;
                        win_dir   <= 2'd0;
                        game_over <= game_over | board_full;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        // Index order: direction fastest, then column, then row
                        d_cnt <= d_cnt + 2'd1;
                        if (d_cnt == 2'd3) begin
                            if (c_cnt == 3'(COLS - 1)) begin
                                c_cnt <= 3'd0;
                                r_cnt <= r_cnt + 3'd1;
                            end else begin
                                c_cnt <= c_cnt + 3'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_scanner.sv
// tb/tb_win_scanner.sv - self-checking bench for win_scanner
module tb_win_scanner;
    import connect4_pkg::*;

    logic       clk_25 = 1'b0;
    logic       rst_n;
    logic       start;
    grid_t      grid;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic [1:0] win_dir;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    win_scanner dut (
        .clk_25    (clk_25),
        .rst_n     (rst_n),
        .start     (start),
        .grid      (grid),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_dir   (win_dir),
        .game_over (game_over)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        string      name;
        grid_t      g;
        logic [1:0] w;
        int         row;
        int         col;
        int         dir;
        int         edges;
        logic       go;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: try every (r,c,d) in scan order, a line matches when all
    // four coordinates lie on the board and hold the same player code.
    function automatic void ref_scan(input grid_t g, output logic [1:0] w,
                                     output int row, output int col,
                                     output int dir, output int edges);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        logic found;
        logic full;
        found = 1'b0;
        w = 2'b00; row = 0; col = 0; dir = 0; edges = 168;
        for (int idx = 0; idx < 168 && !found; idx++) begin
            int r0, c0, d0;
            logic ok;
            r0 = idx / (COLS * 4);
            c0 = (idx / 4) % COLS;
            d0 = idx % 4;
            ok = (g[r0][c0] == 2'b01) || (g[r0][c0] == 2'b10);
            for (int k = 1; k <= 3; k++) begin
                int rr, cc;
                rr = r0 + k * dr[d0];
                cc = c0 + k * dc[d0];
                if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
                else if (g[rr][cc] != g[r0][c0]) ok = 1'b0;
            end
            if (ok) begin
                found = 1'b1;
                w = g[r0][c0]; row = r0; col = c0; dir = d0; edges = idx + 1;
            end
        end
        if (!found) begin
            full = 1'b1;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (g[r][c] == 2'b00) full = 1'b0;
            w = full ? 2'b11 : 2'b00;
        end
    endfunction

    // True when cell (r,c) closes a four with cells placed before it in row-major order
    function automatic logic closes_line(input grid_t g, input int r, input int c);
        int br[4] = '{0, -1, -1, -1};
        int bc[4] = '{-1, 0, -1, 1};
        logic any;
        any = 1'b0;
        for (int d = 0; d < 4; d++) begin
            logic same;
            same = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                int rr, cc;
                rr = r + k * br[d];
                cc = c + k * bc[d];
                if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) same = 1'b0;
                else if (g[rr][cc] != g[r][c]) same = 1'b0;
            end
            if (same) any = 1'b1;
        end
        return any;
    endfunction

    function automatic grid_t gen_full_no_line();
        grid_t g;
        logic ok;
        g = '0;
        for (int t = 0; t < 1000; t++) begin
            ok = 1'b1;
            g = '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (ok) begin
                        g[r][c] = 2'($urandom_range(1, 2));
                        if (closes_line(g, r, c)) begin
                            g[r][c] = 2'b11 ^ g[r][c];
                            if (closes_line(g, r, c)) ok = 1'b0;
                        end
                    end
                end
            end
            if (ok) return g;
        end
        return g;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk_25);
        #1;
        rst_n = 1'b1;
    endtask

    // Pulse start, count edges after edge 0 until done; optionally drive a
    // new grid and/or start pulse right after edge poke_edge.
    task automatic run_scan(input grid_t g, input int poke_edge, input grid_t poke_grid,
                            input logic poke_start, output int edges, output logic [1:0] w,
                            output logic [2:0] wr, output logic [2:0] wc, output logic [1:0] wd);
        edges = -1; w = 2'b00; wr = 3'd0; wc = 3'd0; wd = 2'd0;
        grid  = g;
        start = 1'b1;
        @(posedge clk_25);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk_25);
            #1;
            start = 1'b0;
            if (done) begin
                edges = n; w = winner; wr = win_row; wc = win_col; wd = win_dir;
                break;
            end
            if (n == poke_edge) begin
                grid  = poke_grid;
                start = poke_start;
            end
        end
        if (edges > 0) begin
            @(posedge clk_25);
            #1;
            chk("busy_fall", busy, 0);
            chk("done_one_cycle", done, 0);
        end
    endtask

    grid_t      g;
    int         e_edges, e_row, e_col, e_dir, edges;
    logic [1:0] e_w, w, wd;
    logic [2:0] wr, wc;
    int         done_cnt;

    initial begin
        // Reset with start held high: must not launch a scan
        rst_n = 1'b0;
        start = 1'b1;
        grid  = '0;
        grid[5][0] = P1; grid[5][1] = P1; grid[5][2] = P1; grid[5][3] = P1;
        repeat (3) @(posedge clk_25);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_winner", winner, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_win_dir", win_dir, 0);
        chk("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk_25);
        #1;
        chk("start_in_reset_ignored", busy, 0);

        // Directed table
        g = '0;
        g[5][0] = P1; g[5][1] = P1; g[5][2] = P1; g[5][3] = P1;
        vecs[0] = '{"horiz_p1", g, 2'b01, 5, 0, 0, 141, 1'b1};
        g = '0;
        g[2][3] = P2; g[3][3] = P2; g[4][3] = P2; g[5][3] = P2;
        vecs[1] = '{"vert_p2", g, 2'b10, 2, 3, 1, 70, 1'b1};
        g = '0;
        g[2][3] = P1; g[3][2] = P1; g[4][1] = P1; g[5][0] = P1;
        vecs[2] = '{"diag_dl_p1", g, 2'b01, 2, 3, 3, 72, 1'b1};
        g = '0;
        g[5][0] = P1; g[5][1] = P1; g[5][2] = P1; g[5][3] = P2; g[5][4] = P1;
        g[4][0] = P2; g[3][0] = P2; g[2][0] = P2;
        vecs[3] = '{"partial_none", g, 2'b00, 0, 0, 0, 168, 1'b0};
        vecs[4] = '{"full_draw", gen_full_no_line(), 2'b11, 0, 0, 0, 168, 1'b1};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_scan(vecs[i].g, -1, '0, 1'b0, edges, w, wr, wc, wd);
            chk({vecs[i].name, "_edges"}, edges, vecs[i].edges);
            chk({vecs[i].name, "_winner"}, w, vecs[i].w);
            chk({vecs[i].name, "_win_row"}, wr, vecs[i].row);
            chk({vecs[i].name, "_win_col"}, wc, vecs[i].col);
            chk({vecs[i].name, "_win_dir"}, wd, vecs[i].dir);
            chk({vecs[i].name, "_game_over"}, game_over, vecs[i].go);
        end

        // After the draw, game_over blocks further scans
        start = 1'b1;
        @(posedge clk_25);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            if (busy || done) done_cnt++;
            @(posedge clk_25);
            #1;
        end
        chk("start_after_game_over_ignored", done_cnt, 0);

        // start re-pulsed mid-scan with a different grid: original result stands
        do_reset();
        run_scan(vecs[0].g, 10, vecs[1].g, 1'b1, edges, w, wr, wc, wd);
        chk("repulse_edges", edges, 141);
        chk("repulse_winner", w, 2'b01);
        chk("repulse_win_row", wr, 5);

        // Winning line written into the live grid mid-scan: not seen
        do_reset();
        run_scan(vecs[3].g, 5, vecs[1].g, 1'b0, edges, w, wr, wc, wd);
        chk("midscan_write_edges", edges, 168);
        chk("midscan_write_winner", w, 2'b00);
        chk("midscan_write_game_over", game_over, 0);

        // Reset sampled at edge 50 of a scan: busy drops, no done ever follows
        do_reset();
        grid  = vecs[3].g;
        start = 1'b1;
        @(posedge clk_25);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk_25);
        #1;
        rst_n = 1'b0;
        @(posedge clk_25);
        #1;
        chk("midscan_reset_busy", busy, 0);
        chk("midscan_reset_done", done, 0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk_25);
            #1;
            if (done || busy) done_cnt++;
        end
        chk("midscan_reset_no_done", done_cnt, 0);

        // Randomized boards against the reference model
        for (int t = 0; t < 40; t++) begin
            int dens;
            dens = $urandom_range(5, 90);
            g = '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if ($urandom_range(0, 99) < dens) begin
                        g[r][c] = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(1, 2));
                    end
                end
            end
            if (t % 8 == 7) g = gen_full_no_line();
            ref_scan(g, e_w, e_row, e_col, e_dir, e_edges);
            do_reset();
            run_scan(g, -1, '0, 1'b0, edges, w, wr, wc, wd);
            chk("rand_edges", edges, e_edges);
            chk("rand_winner", w, e_w);
            chk("rand_win_row", wr, e_row);
            chk("rand_win_col", wc, e_col);
            chk("rand_win_dir", wd, e_dir);
            chk("rand_game_over", game_over, (e_w != 2'b00) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
